// File: rtl/frame_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_mask_gen
//  Description : Registered blanking/overlay mask built from NREG
//                programmable rectangles (fill or outline). Region updates are
//                staged in a pending bank and copied to the active bank only
//                on frame_start, so the mask never changes mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_mask_gen #(
  parameter  int NREG   = 4,
  parameter  int XW     = 11,
  parameter  int YW     = 10,
  parameter  int BORDER = 2,
  localparam int IW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XW-1:0]   gr_x,
  input  logic [YW-1:0]   gr_y,
  input  logic            frame_start,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [XW-1:0]   cfg_x1,
  input  logic [XW-1:0]   cfg_x2,
  input  logic [YW-1:0]   cfg_y1,
  input  logic [YW-1:0]   cfg_y2,
  input  logic            cfg_en,
  input  logic            cfg_mode,
  input  logic            cfg_commit,
  output logic            cfg_pending,
  output logic            outbl,
  output logic [NREG-1:0] hit_vec,
  output logic [IW-1:0]   hit_idx,
  output logic            hit_valid
);

  typedef struct packed {
    logic [XW-1:0] x1;
    logic [XW-1:0] x2;
    logic [YW-1:0] y1;
    logic [YW-1:0] y2;
    logic          en;
    logic          mode;
  } region_t;

  // Border thickness widened to the guard-bit compare width.
  localparam logic [XW:0] C_BORDER_X = (XW+1)'(BORDER);
  localparam logic [YW:0] C_BORDER_Y = (YW+1)'(BORDER);

  // Power-on contents: top band and bottom band of a 720x480 frame.
  function automatic region_t f_default(input int idx);
    region_t r;
    r = '0;
    if (idx == 0) begin
      r.x2 = XW'(720);
      r.y2 = YW'(100);
      r.en = 1'b1;
    end else if (idx == 1) begin
      r.x2 = XW'(720);
      r.y1 = YW'(390);
      r.y2 = YW'(480);
      r.en = 1'b1;
    end
    return r;
  endfunction

  region_t         r_pend [NREG];
  region_t         r_act  [NREG];
  logic            r_pending;
  logic [NREG-1:0] r_hit1;
  logic [NREG-1:0] r_hit_vec;
  logic            r_any;
  logic [IW-1:0]   r_idx;

  logic [NREG-1:0] w_hit;
  logic [IW-1:0]   w_idx;
  logic            w_copy;
  logic            w_wr;
  region_t         w_wr_data;

  // A copy happens on frame_start if a commit is armed or arrives this cycle.
  assign w_copy = frame_start & (r_pending | cfg_commit);
  assign w_wr   = cfg_we & (int'(cfg_idx) < NREG);

  assign w_wr_data.x1   = cfg_x1;
  assign w_wr_data.x2   = cfg_x2;
  assign w_wr_data.y1   = cfg_y1;
  assign w_wr_data.y2   = cfg_y2;
  assign w_wr_data.en   = cfg_en;
  assign w_wr_data.mode = cfg_mode;

  // Bank storage and commit flag; the copy reads pending as it was before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_pend[i] <= f_default(i);
        r_act[i]  <= f_default(i);
      end
      r_pending <= 1'b0;
    end else begin
      if (w_copy) begin
        for (int i = 0; i < NREG; i++) r_act[i] <= r_pend[i];
      end
      if (w_wr) r_pend[cfg_idx] <= w_wr_data;
      if (w_copy)          r_pending <= 1'b0;
      else if (cfg_commit) r_pending <= 1'b1;
    end
  end

  // Per-region hit test against the active bank, one guard bit to avoid wrap.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_region
    logic [XW:0] w_x, w_x1, w_x2;
    logic [YW:0] w_y, w_y1, w_y2;
    logic        w_in, w_inner;
    assign w_x  = {1'b0, gr_x};
    assign w_x1 = {1'b0, r_act[gi].x1};
    assign w_x2 = {1'b0, r_act[gi].x2};
    assign w_y  = {1'b0, gr_y};
    assign w_y1 = {1'b0, r_act[gi].y1};
    assign w_y2 = {1'b0, r_act[gi].y2};
    assign w_in = r_act[gi].en & (w_x1 <= w_x) & (w_x <= w_x2)
                               & (w_y1 <= w_y) & (w_y <= w_y2);
    // x <= x2-BORDER rewritten as x+BORDER <= x2 so it stays unsigned; an
    // empty inner box simply never matches and outline degrades to fill.
    assign w_inner = ((w_x1 + C_BORDER_X) <= w_x) & ((w_x + C_BORDER_X) <= w_x2)
                   & ((w_y1 + C_BORDER_Y) <= w_y) & ((w_y + C_BORDER_Y) <= w_y2);
    assign w_hit[gi] = w_in & ~(r_act[gi].mode & w_inner);
  end

  // Lowest-index priority encode of the stage-1 hit bits.
  always_comb begin
    w_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_hit1[i]) w_idx = IW'(i);
    end
  end

  // Two-stage output pipeline, free-running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit1    <= '0;
      r_hit_vec <= '0;
      r_any     <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_hit1    <= w_hit;
      r_hit_vec <= r_hit1;
      r_any     <= |r_hit1;
      r_idx     <= w_idx;
    end
  end

  assign cfg_pending = r_pending;
  assign outbl       = r_any;
  assign hit_valid   = r_any;
  assign hit_vec     = r_hit_vec;
  assign hit_idx     = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_frame_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_mask_gen
//  Description : Scoreboard bench for frame_mask_gen. Directed pixels push
//                their expected hit vector; a monitor pops and compares when
//                the tagged pixel emerges from the 2-cycle pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_mask_gen;
  localparam int NREG = 4;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int BORDER = 2;
  localparam int IW = 2;

  logic            clk;
  logic            reset;
  logic [XW-1:0]   gr_x;
  logic [YW-1:0]   gr_y;
  logic            frame_start;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [XW-1:0]   cfg_x1, cfg_x2;
  logic [YW-1:0]   cfg_y1, cfg_y2;
  logic            cfg_en, cfg_mode, cfg_commit;
  logic            cfg_pending, outbl, hit_valid;
  logic [NREG-1:0] hit_vec;
  logic [IW-1:0]   hit_idx;

  typedef struct {
    logic [NREG-1:0] hv;
    int              x;
    int              y;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic tb_vld = 1'b0;
  logic vd1, vd2;

  frame_mask_gen #(.NREG(NREG), .XW(XW), .YW(YW), .BORDER(BORDER)) dut (
    .clk(clk), .reset(reset), .gr_x(gr_x), .gr_y(gr_y),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x1(cfg_x1), .cfg_x2(cfg_x2), .cfg_y1(cfg_y1), .cfg_y2(cfg_y2),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .outbl(outbl), .hit_vec(hit_vec),
    .hit_idx(hit_idx), .hit_valid(hit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag pipeline matching the DUT latency; cleared by reset like the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      vd1 <= 1'b0;
      vd2 <= 1'b0;
    end else begin
      vd1 <= tb_vld;
      vd2 <= vd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lo_idx(input logic [NREG-1:0] v);
    for (int i = 0; i < NREG; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (vd2) begin
      if (q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (hit_vec !== e.hv)
          $display("  at pixel (%0d,%0d)", e.x, e.y);
        chk("hit_vec", int'(hit_vec), int'(e.hv));
        chk("hit_idx", int'(hit_idx), lo_idx(e.hv));
        chk("outbl", int'(outbl), int'(|e.hv));
        chk("hit_valid", int'(hit_valid), int'(|e.hv));
      end
    end
  end

  // Present one pixel (optionally with frame_start) and queue its expectation.
  task automatic px(input int x, input int y, input logic [NREG-1:0] hv,
                    input logic fs = 1'b0);
    exp_t e;
    e.hv = hv; e.x = x; e.y = y;
    gr_x = XW'(x); gr_y = YW'(y); frame_start = fs; tb_vld = 1'b1;
    q.push_back(e);
    @(negedge clk);
    frame_start = 1'b0; tb_vld = 1'b0;
  endtask

  task automatic wr(input int idx, input int x1, input int x2, input int y1,
                    input int y2, input logic en, input logic mode,
                    input logic commit = 1'b0, input logic fs = 1'b0);
    cfg_idx = IW'(idx); cfg_x1 = XW'(x1); cfg_x2 = XW'(x2);
    cfg_y1 = YW'(y1); cfg_y2 = YW'(y2); cfg_en = en; cfg_mode = mode;
    cfg_we = 1'b1; cfg_commit = commit; frame_start = fs;
    @(negedge clk);
    cfg_we = 1'b0; cfg_commit = 1'b0; frame_start = 1'b0;
  endtask

  task automatic ctl(input logic commit, input logic fs);
    cfg_commit = commit; frame_start = fs;
    @(negedge clk);
    cfg_commit = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; gr_x = '0; gr_y = '0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_x1 = '0; cfg_x2 = '0; cfg_y1 = '0;
    cfg_y2 = '0; cfg_en = 1'b0; cfg_mode = 1'b0; cfg_commit = 1'b0;
    @(negedge clk);
    chk("rst_outbl", int'(outbl), 0);
    chk("rst_hit_vec", int'(hit_vec), 0);
    chk("rst_hit_idx", int'(hit_idx), 0);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_pending", int'(cfg_pending), 0);
    @(negedge clk);
    reset = 1'b1;

    // Default bands: top y 0..100 -> region0, bottom y 390..480 -> region1.
    for (int y = 0; y <= 480; y++)
      px(360, y, {2'b00, (y >= 390) ? 1'b1 : 1'b0, (y <= 100) ? 1'b1 : 1'b0});

    // Outline region2 100..200 with border 2; disable default bands.
    wr(2, 100, 200, 100, 200, 1'b1, 1'b1);
    wr(0, 0, 0, 0, 0, 1'b0, 1'b0);
    wr(1, 0, 0, 0, 0, 1'b0, 1'b0);
    ctl(1'b1, 1'b0);
    chk("pending_armed", int'(cfg_pending), 1);
    ctl(1'b0, 1'b1);
    chk("pending_cleared", int'(cfg_pending), 0);
    px(100, 150, 4'b0100);
    px(101, 150, 4'b0100);
    px(102, 150, 4'b0000);
    px(150, 150, 4'b0000);
    px(199, 199, 4'b0100);
    px(198, 150, 4'b0000);
    px(200, 200, 4'b0100);
    px(201, 150, 4'b0000);
    px(150, 101, 4'b0100);
    px(150, 102, 4'b0000);

    // Double buffering: staged region0 stays invisible until frame_start.
    wr(0, 0, 50, 0, 50, 1'b1, 1'b0);
    ctl(1'b1, 1'b0);
    px(10, 10, 4'b0000);
    chk("dbuf_pending", int'(cfg_pending), 1);
    px(10, 10, 4'b0000, 1'b1);
    chk("dbuf_pending_clr", int'(cfg_pending), 0);
    px(10, 10, 4'b0001);
    px(100, 150, 4'b0100);

    // Commit+frame_start with a same-cycle write to region3.
    wr(1, 40, 60, 40, 60, 1'b1, 1'b0);
    wr(3, 40, 70, 40, 70, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("simul_pending", int'(cfg_pending), 0);
    px(45, 45, 4'b0011);
    px(55, 55, 4'b0010);
    ctl(1'b1, 1'b0);
    ctl(1'b0, 1'b1);
    px(45, 45, 4'b1011);
    px(55, 55, 4'b1010);
    px(65, 65, 4'b1000);

    // Inverted x bounds never hit.
    wr(2, 300, 200, 0, 479, 1'b1, 1'b0);
    ctl(1'b1, 1'b1);
    px(250, 100, 4'b0000);
    px(300, 100, 4'b0000);
    px(200, 100, 4'b0000);
    px(55, 55, 4'b1010);

    // Reset mid-frame while the mask is asserted.
    ctl(1'b1, 1'b0);
    gr_x = XW'(55); gr_y = YW'(55);
    repeat (3) @(negedge clk);
    chk("pre_reset_outbl", int'(outbl), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_outbl", int'(outbl), 0);
    chk("midrst_hit_vec", int'(hit_vec), 0);
    chk("midrst_pending", int'(cfg_pending), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    px(360, 50, 4'b0001);
    px(360, 200, 4'b0000);
    px(360, 400, 4'b0010);
    px(55, 55, 4'b0001);
    // Pending bank must also be back to defaults.
    ctl(1'b1, 1'b1);
    px(55, 55, 4'b0001);
    px(360, 480, 4'b0010);
    px(721, 50, 4'b0000);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
